// File: rtl/uart_reg_file_if.sv
// ---------------------------------------------------------------------------
// uart_reg_file_if
// Host-side bus bundle for the UART register file.
//
// Signals:
//   address     register index for the access
//   writeData   write data
//   byteEnable  per-byte write qualifier (bit k covers bits [8k+7:8k])
//   write       write strobe, one access per cycle high
//   read        read strobe, one access per cycle high
//   readData    registered read data
//   readValid   one-cycle pulse when readData was updated by a read
//   addrError   one-cycle pulse for an access with an out-of-range address
//
// Modports:
//   master  host side (drives the request, receives the response)
//   slave   register file side
// ---------------------------------------------------------------------------
interface uart_reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);

  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   writeData;
  logic [DATA_WIDTH/8-1:0] byteEnable;
  logic                    write;
  logic                    read;
  logic [DATA_WIDTH-1:0]   readData;
  logic                    readValid;
  logic                    addrError;

  modport master (
    output address,
    output writeData,
    output byteEnable,
    output write,
    output read,
    input  readData,
    input  readValid,
    input  addrError
  );

  modport slave (
    input  address,
    input  writeData,
    input  byteEnable,
    input  write,
    input  read,
    output readData,
    output readValid,
    output addrError
  );

endinterface

// File: rtl/uart_reg_file.sv
// ---------------------------------------------------------------------------
// uart_reg_file
// Bus-facing control/status register file for the software-defined UART.
// Registers 1..NUM_REGS-1 are plain byte-enabled read/write words.
// Register 0 is a sticky status word: hardware sets bits through statusSet,
// software clears them by writing 1 (write-1-to-clear). A hardware set in
// the same cycle as a software clear of the same bit leaves the bit set.
//
// Ports:
//   clock_50MHz  system clock, rising edge
//   reset        asynchronous, active-high reset
//   bus          uart_reg_file_if.slave (address, writeData, byteEnable,
//                write, read -> readData, readValid, addrError)
//   statusSet    per-bit set pulses for register 0
//   regFlat      all registers side by side, register i at
//                [i*DATA_WIDTH +: DATA_WIDTH]
//
// readData, readValid and addrError are registered; regFlat is driven
// straight from the register array with no extra stage.
// ---------------------------------------------------------------------------
module uart_reg_file #(
  parameter int                                DATA_WIDTH  = 32,
  parameter int                                NUM_REGS    = 8,
  parameter int                                ADDR_WIDTH  = 3,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VALUE = {(NUM_REGS*DATA_WIDTH){1'b0}}
) (
  input  logic                           clock_50MHz,
  input  logic                           reset,
  uart_reg_file_if.slave                 bus,
  input  logic [DATA_WIDTH-1:0]          statusSet,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regFlat
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_r      [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_next_s [NUM_REGS];

  logic                  addr_ok_s;
  logic                  wr_ok_s;
  logic [DATA_WIDTH-1:0] be_mask_s;
  logic [DATA_WIDTH-1:0] clr_s;
  logic [DATA_WIDTH-1:0] rd_mux_s;

  logic [DATA_WIDTH-1:0] read_data_r;
  logic                  read_valid_r;
  logic                  addr_error_r;

  // Address range check; widened by one bit so NUM_REGS == 2**ADDR_WIDTH fits.
  always_comb begin
    addr_ok_s = ({1'b0, bus.address} < (ADDR_WIDTH + 1)'(NUM_REGS));
    wr_ok_s   = bus.write & addr_ok_s;
  end

  // Expand byte enables into a bit mask.
  always_comb begin
    be_mask_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_BYTES; k++) begin
      be_mask_s[8*k +: 8] = {8{bus.byteEnable[k]}};
    end
  end

  // Next-state for every register: W1C plus sticky set for register 0,
  // byte-merge write for the rest.
  always_comb begin
    if (wr_ok_s && (bus.address == {ADDR_WIDTH{1'b0}})) begin
      clr_s = bus.writeData & be_mask_s;
    end else begin
      clr_s = {DATA_WIDTH{1'b0}};
    end

    // The set term is OR-ed in after the clear so a simultaneous set wins.
    regs_next_s[0] = (regs_r[0] & ~clr_s) | statusSet;

    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_ok_s && (bus.address == ADDR_WIDTH'(i))) begin
        regs_next_s[i] = (regs_r[i] & ~be_mask_s) | (bus.writeData & be_mask_s);
      end else begin
        regs_next_s[i] = regs_r[i];
      end
    end
  end

  // Read mux as an AND-OR tree; an address matching no register yields zero.
  always_comb begin
    rd_mux_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_mux_s = rd_mux_s | ({DATA_WIDTH{bus.address == ADDR_WIDTH'(i)}} & regs_r[i]);
    end
  end

  // Register array state; the status word always resets to zero regardless
  // of its RESET_VALUE slice.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      regs_r[0] <= {DATA_WIDTH{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= regs_next_s[i];
      end
    end
  end

  // Registered read response and address-error pulse. The read samples the
  // pre-write contents, so a same-cycle read+write returns the old value.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      read_data_r  <= {DATA_WIDTH{1'b0}};
      read_valid_r <= 1'b0;
      addr_error_r <= 1'b0;
    end else begin
      read_valid_r <= bus.read;
      addr_error_r <= (bus.read | bus.write) & ~addr_ok_s;
      if (bus.read) begin
        read_data_r <= addr_ok_s ? rd_mux_s : {DATA_WIDTH{1'b0}};
      end else begin
        read_data_r <= read_data_r;
      end
    end
  end

  assign bus.readData  = read_data_r;
  assign bus.readValid = read_valid_r;
  assign bus.addrError = addr_error_r;

  // Flat view of the register array for the UART core.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regFlat[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end

endmodule

// File: tb/tb_uart_reg_file.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_file
// Self-checking bench for uart_reg_file (6 registers, 3-bit address) with a
// behavioural register model, directed scenarios and a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_reg_file;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = 3;
  // reg5, reg4, reg3, reg2, reg1, reg0 (reg0 slice must be ignored)
  localparam logic [NR*DW-1:0] RV = {32'hCAFE_0000, 32'h0000_0000, 32'h0000_1234,
                                     32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   sset;
  logic [NR*DW-1:0] flat;

  uart_reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_reg_file #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .RESET_VALUE(RV)
  ) dut (
    .clock_50MHz(clk),
    .reset      (rst),
    .bus        (bus),
    .statusSet  (sset),
    .regFlat    (flat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] m [NR];
  logic [DW-1:0] exp_rd;
  logic          exp_rv;
  logic          exp_ae;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m[0] = 32'h0000_0000;
    for (int i = 1; i < NR; i++) m[i] = RV[i*DW +: DW];
    exp_rd = 32'h0000_0000;
    exp_rv = 1'b0;
    exp_ae = 1'b0;
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m[i];
    return f;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".readValid"}, {191'd0, bus.readValid}, {191'd0, exp_rv});
    check({tag, ".addrError"}, {191'd0, bus.addrError}, {191'd0, exp_ae});
    check({tag, ".readData"}, {160'd0, bus.readData}, {160'd0, exp_rd});
    check({tag, ".regFlat"}, flat, model_flat());
  endtask

  // One bus cycle: drive at negedge, predict, check just after the posedge.
  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] be,
                      input logic [DW-1:0] ss, input string tag);
    @(negedge clk);
    bus.read = rd; bus.write = wr; bus.address = a;
    bus.writeData = wd; bus.byteEnable = be; sset = ss;
    exp_rv = rd;
    exp_ae = (rd || wr) && (int'(a) >= NR);
    if (rd) exp_rd = (int'(a) < NR) ? m[a] : 32'h0000_0000;
    if (wr && int'(a) < NR) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          if (a == 3'd0) m[0][8*k +: 8] = m[0][8*k +: 8] & ~wd[8*k +: 8];
          else           m[a][8*k +: 8] = wd[8*k +: 8];
        end
      end
    end
    m[0] = m[0] | ss;
    @(posedge clk);
    #1;
    bus.read = 1'b0; bus.write = 1'b0; sset = 32'h0000_0000;
    check_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rs;

    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 3'd0;
    bus.writeData = 32'h0000_0000; bus.byteEnable = 4'h0; sset = 32'h0000_0000;
    model_reset();
    #1;
    check_all("reset");
    check("reset.reg3", {160'd0, flat[3*DW +: DW]}, {160'd0, 32'h0000_1234});
    check("reset.reg0", {160'd0, flat[0 +: DW]}, {160'd0, 32'h0000_0000});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 32'h0, "rd3");
    check("rd3.value", {160'd0, bus.readData}, {160'd0, 32'h0000_1234});

    step(1'b0, 1'b1, 3'd2, 32'hAABB_CCDD, 4'hF, 32'h0, "wr2full");
    step(1'b0, 1'b1, 3'd2, 32'h1122_3344, 4'b0101, 32'h0, "wr2be");
    check("wr2be.value", {160'd0, flat[2*DW +: DW]}, {160'd0, 32'hAA22_CC44});
    step(1'b1, 1'b0, 3'd2, 32'h0, 4'h0, 32'h0, "rd2");

    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0000_0005, "sset5");
    check("sset5.value", {160'd0, flat[0 +: DW]}, {160'd0, 32'h0000_0005});
    step(1'b0, 1'b1, 3'd0, 32'h0000_0001, 4'hF, 32'h0, "w1c");
    check("w1c.value", {160'd0, flat[0 +: DW]}, {160'd0, 32'h0000_0004});
    step(1'b0, 1'b1, 3'd0, 32'h0000_0004, 4'hF, 32'h0000_0004, "setwins");
    check("setwins.value", {160'd0, flat[0 +: DW]}, {160'd0, 32'h0000_0004});

    step(1'b1, 1'b1, 3'd1, 32'hDEAD_BEEF, 4'hF, 32'h0, "rw1");
    check("rw1.old", {160'd0, bus.readData}, {160'd0, 32'h0000_0000});
    step(1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 32'h0, "rd1");
    check("rd1.new", {160'd0, bus.readData}, {160'd0, 32'hDEAD_BEEF});

    step(1'b0, 1'b1, 3'd7, 32'h1234_5678, 4'hF, 32'h0, "wr7");
    check("wr7.err", {191'd0, bus.addrError}, {191'd0, 1'b1});
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0, "idle1");
    step(1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h0, "rd6");
    check("rd6.zero", {160'd0, bus.readData}, {160'd0, 32'h0000_0000});
    step(1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0, "rw7");
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0, "idle2");
    step(1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 32'h0, "rd5");

    // Reset lands while a read is pending at the next edge.
    @(negedge clk);
    bus.read = 1'b1; bus.address = 3'd3;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rstasync");
    @(posedge clk);
    #1;
    check_all("rsthold");
    @(negedge clk);
    bus.read = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("rstrelease");

    for (int a = 1; a <= 5; a++) begin
      step(1'b1, 1'b0, AW'(a), 32'h0, 4'h0, 32'h0, "b2b");
    end

    for (int n = 0; n < 300; n++) begin
      ra = AW'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0000_0000;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom,
           4'($urandom_range(0, 15)), rs, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
